// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared types and constants for the AXI-Stream demux router.
//               Holds the router state encoding, the drop-counter width and
//               a saturating-increment helper for that counter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Router state encoding (values are fixed; software/debug may read them)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int DROP_CNT_WIDTH = 16;

  // Increment that sticks at all-ones instead of wrapping to zero
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    logic [DROP_CNT_WIDTH-1:0] one;
    one = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : (v + one);
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buf
// Description : Two-entry skid register. A beat pushed on cycle N is visible
//               at the output on cycle N+1; with the sink always ready the
//               buffer sustains one beat per cycle at occupancy one. The
//               second entry absorbs the beat that is already in flight when
//               the sink stalls, so the upstream ready can be registered.
// Ports       : clk_i, rst_i   - clock, asynchronous active-high reset
//               in_vld_i       - push request (caller only pushes when the
//                                registered ready it derived was high)
//               in_dat_i       - push payload
//               full_nxt_o     - occupancy will be two after this edge;
//                                used by the caller to register its ready
//               out_vld_o      - head entry valid
//               out_dat_o      - head entry payload (held while not popped)
//               out_rdy_i      - sink accepts the head entry
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             full_nxt_o,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o,
  input  logic             out_rdy_i
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;   // head entry, drives the output
  logic [WIDTH-1:0] ent1_q, ent1_d;   // overflow entry
  logic             push, pop;

  assign out_vld_o  = (count_q != 2'd0);
  assign out_dat_o  = ent0_q;
  // A push into a full buffer would overwrite live data, so it is refused
  assign push       = in_vld_i && (count_q != 2'd2);
  assign pop        = out_vld_o && out_rdy_i;
  assign full_nxt_o = (count_d == 2'd2);

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    unique case ({push, pop})
      2'b11: begin
        // Occupancy unchanged; the new beat lands behind whatever remains
        if (count_q == 2'd1) begin
          ent0_d = in_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_dat_i;
        end
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = in_dat_i;
        end else begin
          ent1_d = in_dat_i;
        end
        count_d = count_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule : axis_skid_buf
`default_nettype wire

// File: rtl/axis_demux_router.sv
`default_nettype none
// ============================================================================
// Module      : axis_demux_router
// Description : Packet-level AXI-Stream 1:N demultiplexer. The destination
//               is sampled from a one-hot select on the first beat of each
//               packet and locked until the last beat. Packets whose select
//               is not one-hot are absorbed and counted. Output beats pass
//               through a two-entry skid register tagged with the port.
// Ports       : clk_i, rst_i     - clock, asynchronous active-high reset
//               demux_ctrl_i     - one-hot destination (first beat only)
//               s_axi_dat_i/vld_i/lst_i, s_axi_rdy_o - slave stream
//               m_axi_dat_o      - head payload replicated on every lane
//               m_axi_vld_o/lst_o/rdy_i - per-port master handshake
//               drop_cnt_o       - saturating count of discarded packets
//               busy_o           - a packet is in progress (not IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_demux_router
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_NUM   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [PORT_NUM-1:0]            demux_ctrl_i,
  input  logic [DATA_WIDTH-1:0]          s_axi_dat_i,
  input  logic                           s_axi_vld_i,
  input  logic                           s_axi_lst_i,
  output logic                           s_axi_rdy_o,
  output logic [DATA_WIDTH*PORT_NUM-1:0] m_axi_dat_o,
  output logic [PORT_NUM-1:0]            m_axi_vld_o,
  output logic [PORT_NUM-1:0]            m_axi_lst_o,
  input  logic [PORT_NUM-1:0]            m_axi_rdy_i,
  output logic [DROP_CNT_WIDTH-1:0]      drop_cnt_o,
  output logic                           busy_o
);

  localparam int IDX_W  = $clog2(PORT_NUM);
  localparam int SKID_W = DATA_WIDTH + 1 + IDX_W;
  localparam logic [PORT_NUM-1:0] CTRL_ONE = {{(PORT_NUM-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          port_q, port_d;        // locked destination
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      s_rdy_q, s_rdy_d;

  // --------------------------------------------------------------------------
  // Select decode
  // --------------------------------------------------------------------------
  logic             ctrl_onehot;
  logic [IDX_W-1:0] ctrl_idx;

  // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot
  assign ctrl_onehot = (demux_ctrl_i != '0) &&
                       ((demux_ctrl_i & (demux_ctrl_i - CTRL_ONE)) == '0);

  always_comb begin
    ctrl_idx = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (demux_ctrl_i[k]) begin
        ctrl_idx = IDX_W'(k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Skid register
  // --------------------------------------------------------------------------
  logic                  accept;
  logic                  skid_push;
  logic [IDX_W-1:0]      push_idx;
  logic [SKID_W-1:0]     skid_in;
  logic                  skid_full_nxt;
  logic                  skid_vld;
  logic [SKID_W-1:0]     skid_out;
  logic                  skid_rdy;
  logic [IDX_W-1:0]      head_idx;
  logic                  head_lst;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [PORT_NUM-1:0]   port_sel;

  assign accept  = s_axi_vld_i && s_rdy_q;
  assign skid_in = {push_idx, s_axi_lst_i, s_axi_dat_i};
  assign {head_idx, head_lst, head_dat} = skid_out;

  axis_skid_buf #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_vld_i   (skid_push),
    .in_dat_i   (skid_in),
    .full_nxt_o (skid_full_nxt),
    .out_vld_o  (skid_vld),
    .out_dat_o  (skid_out),
    .out_rdy_i  (skid_rdy)
  );

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    drop_cnt_d = drop_cnt_q;
    skid_push  = 1'b0;
    push_idx   = port_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ctrl_onehot) begin
            skid_push = 1'b1;
            push_idx  = ctrl_idx;
            port_d    = ctrl_idx;
            if (!s_axi_lst_i) begin
              state_d = ST_PASS;
            end
          end else begin
            // The whole packet counts once, on its first beat
            drop_cnt_d = sat_inc(drop_cnt_q);
            if (!s_axi_lst_i) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_PASS: begin
        if (accept) begin
          skid_push = 1'b1;
          if (s_axi_lst_i) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axi_lst_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered from the next state so it never depends
    // combinationally on m_axi_rdy_i. Discarding needs no buffer space.
    s_rdy_d = (state_d == ST_DROP) || !skid_full_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      port_q     <= '0;
      drop_cnt_q <= '0;
      s_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      drop_cnt_q <= drop_cnt_d;
      s_rdy_q    <= s_rdy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output fan-out
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
    assign port_sel[k]    = skid_vld && (head_idx == IDX_W'(k));
    assign m_axi_vld_o[k] = port_sel[k];
    assign m_axi_lst_o[k] = port_sel[k] && head_lst;
    assign m_axi_dat_o[k*DATA_WIDTH +: DATA_WIDTH] = head_dat;
  end

  // Only the addressed port's ready can pop the head entry
  assign skid_rdy    = |(m_axi_rdy_i & port_sel);

  assign s_axi_rdy_o = s_rdy_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule : axis_demux_router
`default_nettype wire
